// File: rtl/rca_bist_if.sv
// Adder-side and status bus of the ripple-carry adder BIST engine.
// RCA_BIST_FIRST_FAIL_EN adds the first-failure capture signals.
interface rca_bist_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     x_o;
    logic [WIDTH-1:0]     y_o;
    logic                 cin_o;
    logic [WIDTH:0]       sum_i;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH+1:0]   err_count;
`ifdef RCA_BIST_FIRST_FAIL_EN
    logic [2*WIDTH:0]     fail_vec;
    logic [WIDTH:0]       fail_sum;
    logic                 fail_valid;

    modport master (
        input  start, sum_i,
        output x_o, y_o, cin_o, busy, done, pass, err_count,
        output fail_vec, fail_sum, fail_valid
    );

    modport slave (
        output start, sum_i,
        input  x_o, y_o, cin_o, busy, done, pass, err_count,
        input  fail_vec, fail_sum, fail_valid
    );
`else
    modport master (
        input  start, sum_i,
        output x_o, y_o, cin_o, busy, done, pass, err_count
    );

    modport slave (
        output start, sum_i,
        input  x_o, y_o, cin_o, busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/rca_bist.sv
// Exhaustive BIST sweep for a WIDTH-bit ripple-carry adder: drives every {cin, x, y}
// vector, checks sum_i against a golden sum. Optional macro: RCA_BIST_FIRST_FAIL_EN.
module rca_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    rca_bist_if.master    bus
);
    localparam int VW = 2*WIDTH + 1;
    localparam int CW = 2*WIDTH + 2;
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [VW-1:0] LAST_VEC  = '1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [WW-1:0]   wcnt;
    logic [CW-1:0]   errs;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic [WIDTH:0]  golden;
    logic            mismatch;
`ifdef RCA_BIST_FIRST_FAIL_EN
    logic [VW-1:0]   fvec;
    logic [WIDTH:0]  fsum;
    logic            fvalid;
`endif

    // Operands come straight from the vector register, so they are registered outputs.
    assign bus.y_o   = vec[WIDTH-1:0];
    assign bus.x_o   = vec[2*WIDTH-1:WIDTH];
    assign bus.cin_o = vec[2*WIDTH];

    assign golden   = {1'b0, bus.x_o} + {1'b0, bus.y_o} + {{WIDTH{1'b0}}, bus.cin_o};
    assign mismatch = (golden != bus.sum_i);

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = errs;
`ifdef RCA_BIST_FIRST_FAIL_EN
    assign bus.fail_vec   = fvec;
    assign bus.fail_sum   = fsum;
    assign bus.fail_valid = fvalid;
`endif

    // pass is resolved on the final CHECK edge, folding in that vector's own result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            vec    <= '0;
            wcnt   <= '0;
            errs   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
`ifdef RCA_BIST_FIRST_FAIL_EN
            fvec   <= '0;
            fsum   <= '0;
            fvalid <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        vec    <= '0;
                        wcnt   <= '0;
                        errs   <= '0;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                        pass_r <= 1'b0;
`ifdef RCA_BIST_FIRST_FAIL_EN
                        fvec   <= '0;
                        fsum   <= '0;
                        fvalid <= 1'b0;
`endif
                        state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (wcnt == WAIT_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        errs <= errs + CW'(1);
`ifdef RCA_BIST_FIRST_FAIL_EN
                        if (!fvalid) begin
                            fvec   <= vec;
                            fsum   <= bus.sum_i;
                            fvalid <= 1'b1;
                        end
`endif
                    end
                    if (vec == LAST_VEC) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= !mismatch && (errs == '0);
                        state  <= S_DONE;
                    end else begin
                        vec   <= vec + VW'(1);
                        wcnt  <= '0;
                        state <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
